// File: rtl/nt_serializer.sv
// nt_serializer: parallel-to-serial transmitter, MSB-first, programmable field length.
// Ports: clk, rst (async active-low), ld_cnt/parin/init load, cnt shift enable,
//   out serial data, busy frame-in-flight, done one-cycle end pulse.
// Optional even-parity trailer bit: define NT_SER_PARITY_EN.
module nt_serializer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_cnt,
  input  logic [DATA_W-1:0] parin,
  input  logic [CNT_W-1:0]  init,
  input  logic              cnt,
  output logic              out,
  output logic              busy,
  output logic              done
);

`ifdef NT_SER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd3
  } state_t;
`endif

  state_t            state_q;
  logic [DATA_W-1:0] sreg_q;
  logic [CNT_W-1:0]  idx_q;
  logic [CNT_W-1:0]  idx_d;
  logic              out_q;
  logic              busy_q;
  logic              done_q;
  logic              bit_cur;

`ifdef NT_SER_PARITY_EN
  logic par_q;
`endif

  assign bit_cur = sreg_q[idx_q];
  assign idx_d   = idx_q - CNT_W'(1);

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      idx_q   <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef NT_SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          out_q  <= 1'b0;
          done_q <= 1'b0;
          if (ld_cnt) begin
            sreg_q  <= parin;
            idx_q   <= init;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
`ifdef NT_SER_PARITY_EN
            par_q   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          if (cnt) begin
            out_q <= bit_cur;
`ifdef NT_SER_PARITY_EN
            par_q <= par_q ^ bit_cur;
`endif
            if (idx_q == '0) begin
`ifdef NT_SER_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= DONE;
`endif
            end else begin
              idx_q <= idx_d;
            end
          end
        end
`ifdef NT_SER_PARITY_EN
        PARITY: begin
          if (cnt) begin
            out_q   <= par_q;
            state_q <= DONE;
          end
        end
`endif
        DONE: begin
          // First DONE cycle still shows the last bit; the
          // pulse cycle follows so a load then is ignored.
          if (!done_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            out_q  <= 1'b0;
          end else begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nt_serializer.sv
// tb_nt_serializer: randomized and directed checks of nt_serializer
// against a queue-based frame model.
module tb_nt_serializer;

  logic       clk;
  logic       rst;
  logic       ld_cnt;
  logic [7:0] parin;
  logic [2:0] init;
  logic       cnt;
  logic       out;
  logic       busy;
  logic       done;

  int ncmp;
  int nfail;

  nt_serializer #(.DATA_W(8), .CNT_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .ld_cnt(ld_cnt),
    .parin(parin),
    .init(init),
    .cnt(cnt),
    .out(out),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: cnt always 1; mode 1: random cnt;
  // mode 2: cnt low for 2 edges after the 3rd bit.
  task automatic run_frame(input logic [7:0] w,
                           input logic [2:0] ini,
                           input int mode,
                           input bit noise);
    logic bits[$];
    int   nb, ndata, pos, edges, stalls, phase;
    logic eo, eb, ed, c, p;
    logic [7:0] rx, mask;
    bits  = {};
    p     = 1'b0;
    ndata = int'(ini) + 1;
    for (int i = int'(ini); i >= 0; i--) begin
      bits.push_back(w[i]);
      p = p ^ w[i];
    end
`ifdef NT_SER_PARITY_EN
    bits.push_back(p);
`endif
    nb   = bits.size();
    mask = 8'((9'h1 << ndata) - 9'h1);
    rx   = '0;
    @(negedge clk);
    ld_cnt = 1'b1;
    parin  = w;
    init   = ini;
    cnt    = 1'($urandom);
    @(posedge clk);
    #1;
    check("load_busy", busy, 1);
    check("load_out", out, 0);
    check("load_done", done, 0);
    pos = 0; edges = 0; stalls = 0; phase = 0;
    eo = 1'b0; eb = 1'b1; ed = 1'b0;
    for (int n = 0; n < 100 && phase < 3; n++) begin
      @(negedge clk);
      case (mode)
        0:       c = 1'b1;
        1:       c = ($urandom % 4) != 0;
        default: c = !(pos == 3 && stalls < 2);
      endcase
      if (noise) begin
        ld_cnt = (phase >= 1) ? 1'b1 : 1'($urandom);
        parin  = 8'hFF;
        init   = 3'($urandom);
      end else begin
        ld_cnt = 1'b0;
      end
      cnt = c;
      @(posedge clk);
      edges++;
      if (phase == 0) begin
        if (c) begin
          eo = bits[pos];
          pos++;
          if (pos == nb) phase = 1;
        end else begin
          stalls++;
        end
      end else if (phase == 1) begin
        phase = 2;
        eo = 1'b0; eb = 1'b0; ed = 1'b1;
      end else begin
        phase = 3;
        ed = 1'b0;
      end
      #1;
      check("out", out, eo);
      check("busy", busy, eb);
      check("done", done, ed);
      if (c && (phase == 0 || (phase == 1 && edges > 0)) && pos <= ndata
          && eb && !ed && rx_take(pos, ndata, phase))
        rx = {rx[6:0], out};
      if (phase == 2) check("done_time", edges, nb + 1 + stalls);
    end
    check("frame_end", phase, 3);
    check("loopback", rx, w & mask);
    ld_cnt = 1'b0;
  endtask

  // A bit is captured on the edge that presented it.
  function automatic bit rx_take(input int pos, input int ndata,
                                 input int phase);
    return pos >= 1 && pos <= ndata && phase <= 1;
  endfunction

  initial begin
    ncmp = 0; nfail = 0;
    rst = 1'b0; ld_cnt = 1'b0; parin = '0; init = '0; cnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;

    run_frame(8'b1011_0010, 3'd7, 0, 1'b0);
    run_frame(8'hA5, 3'd3, 0, 1'b0);
    run_frame(8'b1011_0010, 3'd7, 2, 1'b0);
    run_frame(8'b1011_0010, 3'd7, 0, 1'b1);
    run_frame(8'h02, 3'd2, 0, 1'b0);

    // Reset mid-frame: 3rd bit of 1011_0010 is a 1.
    @(negedge clk);
    ld_cnt = 1'b1; parin = 8'b1011_0010; init = 3'd7; cnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ld_cnt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_out", out, 1);
    check("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_out", out, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("post_rst_out", out, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_done", done, 0);
    end

    for (int f = 0; f < 20; f++)
      run_frame(8'($urandom), 3'($urandom), 1, 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
